pwm_multichannel: RTL and testbench
===================================

# pwm_multichannel

Parametrised multi-channel PWM generator for the photonic-switch drivers. It generalises the single-channel set/reset PWM path to N_CH channels with a built-in prescaler, edge- or center-aligned counting, and glitch-free shadow-register updates. It sits between the core-clock control logic, which supplies the prescale, period and duty words, and the switch driver pins.

## Interface
- N_CH, 4: number of PWM channels.
- CNT_W, 13: counter, period and duty width in bits.
- PRE_W, 5: prescaler width; the tick divide ratio is prescale+1.

- clk  in  1  core clock. All logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run enable. When low, the prescaler and counter hold.
- prescale  in  PRE_W  prescaler terminal value.
- period  in  CNT_W  requested period value P.
- duty  in  N_CH*CNT_W  requested duty per channel; channel i uses bits [i*CNT_W +: CNT_W].
- center_mode  in  1  requested mode: 0 = edge-aligned, 1 = center-aligned.
- load  in  1  one-clk strobe. It captures prescale, period, duty and center_mode into staging registers.
- tick  out  1  prescaled enable. It is a 1-clk pulse.
- count  out  CNT_W  main counter value.
- pwm_out  out  N_CH  PWM outputs.
- pwm_set  out  N_CH  1-clk pulse in the cycle pwm_out[i] rises.
- pwm_reset  out  N_CH  1-clk pulse in the cycle pwm_out[i] falls.
- cycle_start  out  1  1-clk pulse in the cycle count returns to 0 at a boundary.
- load_ack  out  1  1-clk pulse in the cycle the staged values become active.

## Operation
- **Register sets.** There are three: staging, pending flag, and active (shadow) registers for prescale, period, duty and mode. Only the active set drives the counter and the comparators.
- **Load.** When load=1, staging takes the inputs and pending is set. A later load before the boundary overwrites staging; the last load wins.
- **Prescaler.** pre counts 0..prescale_act while en=1. tick=1 in the cycle pre==prescale_act and en=1, and pre then wraps to 0. prescale_act=0 gives tick on every en cycle.
- **Edge mode.** On each tick, count goes count+1, or to 0 when count==P_act; the wrap to 0 is the boundary. The period is P+1 ticks. P=0 gives a boundary on every tick.
- **Center mode, up direction, on tick:**
  - count<P: count+1.
  - count==P and P>=2: count becomes P-1 and dir goes down.
  - count==P and P<=1: count becomes 0. This is a boundary.
- **Center mode, down direction, on tick:**
  - count>=2: count-1.
  - count==1: count becomes 0 and dir goes up. This is a boundary.
- **Center period.** The period is 2P ticks for P>=1 and 1 tick for P=0.
- **Boundary.** If pending=1, the active set takes staging, pending clears, dir is forced up, and load_ack pulses. The new prescale takes effect from the next prescaler cycle. cycle_start pulses on every boundary.
- **Compare.** The raw compare for channel i is (count < duty_act[i]), unsigned. duty=0 keeps the output low. duty>P in edge mode, or duty>P in center mode, keeps the output permanently high.
- **Output edges.** pwm_set and pwm_reset are edge detects on the registered pwm_out. At most one of them asserts per channel per cycle.
- **en low.** pre, count, dir and pwm_out hold. tick, cycle_start and the set/reset pulses are 0. load is still captured. No boundary can occur, so pending persists.
- **Reset values.** All outputs are 0: count=0, pwm_out=0, tick=0, cycle_start=0, load_ack=0. All active and staging registers are 0, pending=0, dir=up, pre=0.
- **Reset mid-operation.** Reset returns everything to the reset values on the next clk, and staged values are discarded.

## Timing
- tick is registered alongside pre. count updates on the clk edge at which tick=1, so the new count is visible in the cycle after tick.
- pwm_out[i] is registered from the compare of the current count and duty_act. It lags count by 1 clk.
- pwm_set[i] and pwm_reset[i] assert in the same cycle as the pwm_out[i] transition.
- cycle_start and load_ack assert in the same cycle as count==0 after the boundary. The first pwm_out using the new duty appears 1 clk later.
- load to active latency: from 1 clk up to one full PWM period.
- If load and the boundary occur in the same cycle, the inputs from that cycle are captured and applied at the next boundary, not the current one.

## Test plan
- **Edge mode, basic.** Reset, then load prescale=0, P=9, duty0=3, edge mode, en=1. Required: first load_ack at the first boundary; afterwards pwm_out[0] high 3 clks of every 10, cycle_start every 10 clks, and one pwm_set and one pwm_reset per period.
- **Mid-period update.** While duty0=3 is active, load duty0=7 when count=4. Required: the current period stays 3 high. load_ack occurs at the next count=0. Subsequent periods are 7 high of 10.
- **Duty extremes.** duty1=0 and duty2=15 with P=9. Required: pwm_out[1] always 0 and pwm_out[2] always 1 after the first output cycle, with no set/reset pulses after the initial rise of channel 2.
- **Center mode.** P=4, duty0=2, center mode. Required: count sequence 0,1,2,3,4,3,2,1 repeating; pwm_out high 3 of 8 ticks (counts 0,1,1), lagging count by 1 clk; cycle_start every 8.
- **Prescaler and enable.** prescale=4, P=3, edge mode. Required: tick every 5 clks and a period of 20 clks. Dropping en for 7 clks freezes count and pwm_out, and the sequence resumes from the same values.
- **Reset mid-operation.** Assert reset for 1 clk mid-period with pending=1. Required: on the next clk all outputs are 0 and pending=0. There is no load_ack until a new load is issued.

Source files
------------

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: shared prescaler and counter (edge or center aligned),
// per-channel comparators, staged settings applied only at period boundaries.
module pwm_multichannel #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 13,
    parameter int unsigned PRE_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [PRE_W-1:0]      prescale,
    input  logic [CNT_W-1:0]      period,
    input  logic [N_CH*CNT_W-1:0] duty,
    input  logic                  center_mode,
    input  logic                  load,
    output logic                  tick,
    output logic [CNT_W-1:0]      count,
    output logic [N_CH-1:0]       pwm_out,
    output logic [N_CH-1:0]       pwm_set,
    output logic [N_CH-1:0]       pwm_reset,
    output logic                  cycle_start,
    output logic                  load_ack
);

    typedef enum logic {DirUp, DirDown} dir_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntTwo = CNT_W'(2);
    localparam logic [PRE_W-1:0] PreOne = PRE_W'(1);

    logic [PRE_W-1:0]      stg_prescale_q, act_prescale_q;
    logic [CNT_W-1:0]      stg_period_q, act_period_q;
    logic [N_CH*CNT_W-1:0] stg_duty_q, act_duty_q;
    logic                  stg_mode_q, act_mode_q;
    logic                  pending_q, pending_d;

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic                  tick_q, tick_d;
    logic [CNT_W-1:0]      count_q, count_d;
    dir_e                  dir_q, dir_d;
    logic [N_CH-1:0]       pwm_q, pwm_prev_q, cmp;
    logic                  cycle_start_q, load_ack_q;

    logic                  tick_run;
    logic                  boundary;
    logic                  apply;

    assign tick_run = tick_q & en;

    // Prescaler; the >= guards against a smaller prescale landing while pre is mid-count.
    always_comb begin
        pre_d  = pre_q;
        tick_d = tick_q;
        if (en) begin
            if (pre_q >= act_prescale_q) begin
                pre_d  = '0;
                tick_d = 1'b1;
            end else begin
                pre_d  = pre_q + PreOne;
                tick_d = 1'b0;
            end
        end
    end

    always_comb begin
        count_d  = count_q;
        dir_d    = dir_q;
        boundary = 1'b0;
        if (tick_run) begin
            if (!act_mode_q) begin
                if (count_q == act_period_q) begin
                    count_d  = '0;
                    boundary = 1'b1;
                end else begin
                    count_d = count_q + CntOne;
                end
            end else if (dir_q == DirUp) begin
                if (count_q < act_period_q) begin
                    count_d = count_q + CntOne;
                end else if (act_period_q >= CntTwo) begin
                    count_d = act_period_q - CntOne;
                    dir_d   = DirDown;
                end else begin
                    count_d  = '0;
                    boundary = 1'b1;
                end
            end else begin
                if (count_q >= CntTwo) begin
                    count_d = count_q - CntOne;
                end else begin
                    count_d  = '0;
                    dir_d    = DirUp;
                    boundary = 1'b1;
                end
            end
        end
        apply = boundary & pending_q;
        if (apply) begin
            dir_d = DirUp;
        end
        // A load coinciding with the boundary stays pending for the next one.
        pending_d = load ? 1'b1 : (apply ? 1'b0 : pending_q);
    end

    always_comb begin
        cmp = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            cmp[i] = count_q < act_duty_q[i*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_prescale_q <= '0;
            stg_period_q   <= '0;
            stg_duty_q     <= '0;
            stg_mode_q     <= 1'b0;
            act_prescale_q <= '0;
            act_period_q   <= '0;
            act_duty_q     <= '0;
            act_mode_q     <= 1'b0;
            pending_q      <= 1'b0;
            pre_q          <= '0;
            tick_q         <= 1'b0;
            count_q        <= '0;
            dir_q          <= DirUp;
            pwm_q          <= '0;
            pwm_prev_q     <= '0;
            cycle_start_q  <= 1'b0;
            load_ack_q     <= 1'b0;
        end else begin
            if (load) begin
                stg_prescale_q <= prescale;
                stg_period_q   <= period;
                stg_duty_q     <= duty;
                stg_mode_q     <= center_mode;
            end
            if (apply) begin
                act_prescale_q <= stg_prescale_q;
                act_period_q   <= stg_period_q;
                act_duty_q     <= stg_duty_q;
                act_mode_q     <= stg_mode_q;
            end
            pending_q <= pending_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            // Pulse sources hold while disabled so no edge is lost across a pause.
            if (en) begin
                pwm_q         <= cmp;
                pwm_prev_q    <= pwm_q;
                cycle_start_q <= boundary;
                load_ack_q    <= apply;
            end
        end
    end

    assign tick        = tick_run;
    assign count       = count_q;
    assign pwm_out     = pwm_q;
    assign pwm_set     = {N_CH{en}} & pwm_q & ~pwm_prev_q;
    assign pwm_reset   = {N_CH{en}} & ~pwm_q & pwm_prev_q;
    assign cycle_start = cycle_start_q & en;
    assign load_ack    = load_ack_q & en;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: edge/center modes, shadow updates, prescaler,
// enable freeze and mid-operation reset, all against hand-derived counts.
module tb_pwm_multichannel;

    localparam int N_CH  = 4;
    localparam int CNT_W = 13;
    localparam int PRE_W = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  en;
    logic [PRE_W-1:0]      prescale;
    logic [CNT_W-1:0]      period;
    logic [N_CH*CNT_W-1:0] duty;
    logic                  center_mode;
    logic                  load;
    logic                  tick;
    logic [CNT_W-1:0]      count;
    logic [N_CH-1:0]       pwm_out;
    logic [N_CH-1:0]       pwm_set;
    logic [N_CH-1:0]       pwm_reset;
    logic                  cycle_start;
    logic                  load_ack;

    pwm_multichannel #(
        .N_CH (N_CH),
        .CNT_W(CNT_W),
        .PRE_W(PRE_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .prescale   (prescale),
        .period     (period),
        .duty       (duty),
        .center_mode(center_mode),
        .load       (load),
        .tick       (tick),
        .count      (count),
        .pwm_out    (pwm_out),
        .pwm_set    (pwm_set),
        .pwm_reset  (pwm_reset),
        .cycle_start(cycle_start),
        .load_ack   (load_ack)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int hi[N_CH];
    int st[N_CH];
    int rs[N_CH];
    int n_cs;
    int n_ack;
    int n_tick;
    int n_bad_cnt;
    int n_bad_pwm;

    int exp_cnt[9] = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
    int exp_pwm[9] = '{0, 1, 1, 0, 0, 0, 0, 0, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_acc();
        for (int i = 0; i < N_CH; i++) begin
            hi[i] = 0;
            st[i] = 0;
            rs[i] = 0;
        end
        n_cs   = 0;
        n_ack  = 0;
        n_tick = 0;
    endtask

    task automatic cyc();
        for (int i = 0; i < N_CH; i++) begin
            hi[i] += int'(pwm_out[i]);
            st[i] += int'(pwm_set[i]);
            rs[i] += int'(pwm_reset[i]);
        end
        n_cs   += int'(cycle_start);
        n_ack  += int'(load_ack);
        n_tick += int'(tick);
        step();
    endtask

    task automatic wait_ack(input string tag, input int budget);
        for (int i = 0; i < budget && load_ack !== 1'b1; i++) step();
        check(tag, load_ack, 1);
    endtask

    task automatic wait_cs(input string tag, input int budget);
        step();
        for (int i = 0; i < budget && cycle_start !== 1'b1; i++) step();
        check(tag, cycle_start, 1);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_count"}, count, 0);
        check({pfx, "_pwm"}, pwm_out, 0);
        check({pfx, "_tick"}, tick, 0);
        check({pfx, "_cs"}, cycle_start, 0);
        check({pfx, "_ack"}, load_ack, 0);
        check({pfx, "_set"}, pwm_set, 0);
        check({pfx, "_rst"}, pwm_reset, 0);
    endtask

    initial begin
        reset       = 1'b1;
        en          = 1'b0;
        load        = 1'b0;
        prescale    = '0;
        period      = '0;
        duty        = '0;
        center_mode = 1'b0;
        repeat (3) step();
        check_zero("rst");

        // Edge mode P=9, ch0=3, ch1=0, ch2=15 (above P), ch3=0.
        reset    = 1'b0;
        en       = 1'b1;
        period   = 13'd9;
        duty     = {13'd0, 13'd15, 13'd0, 13'd3};
        load     = 1'b1;
        step();
        load = 1'b0;
        check("edge_tick1", tick, 1);
        check("edge_noack_early", load_ack, 0);
        step();
        check("edge_first_ack", load_ack, 1);
        check("edge_first_cs", cycle_start, 1);
        check("edge_first_count", count, 0);

        clear_acc();
        repeat (10) cyc();
        check("edge_p1_hi0", hi[0], 3);
        check("edge_p1_set0", st[0], 1);
        check("edge_p1_rst0", rs[0], 1);
        check("edge_p1_cs", n_cs, 1);
        check("edge_p1_hi1", hi[1], 0);
        check("edge_p1_hi2", hi[2], 9);
        check("edge_p1_set2", st[2], 1);

        clear_acc();
        repeat (10) cyc();
        check("edge_p2_hi0", hi[0], 3);
        check("edge_p2_set0", st[0], 1);
        check("edge_p2_rst0", rs[0], 1);
        check("edge_p2_cs", n_cs, 1);
        check("ext_hi1", hi[1], 0);
        check("ext_hi2", hi[2], 10);
        check("ext_set2", st[2], 0);
        check("ext_rst2", rs[2], 0);
        check("edge_p3_count0", count, 0);
        check("edge_p3_cs", cycle_start, 1);

        // Mid-period duty change loaded at count=4.
        clear_acc();
        repeat (4) cyc();
        check("mid_count4", count, 4);
        duty = {13'd0, 13'd15, 13'd0, 13'd7};
        load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (5) cyc();
        check("mid_cur_hi0", hi[0], 3);
        check("mid_no_ack", n_ack, 0);
        check("mid_ack", load_ack, 1);
        check("mid_ack_count", count, 0);
        clear_acc();
        repeat (10) cyc();
        check("mid_new_hi0", hi[0], 7);
        check("mid_new_set0", st[0], 1);
        check("mid_new_rst0", rs[0], 1);
        check("mid_new_ack", n_ack, 1);

        // Center mode P=4, ch0=2.
        period      = 13'd4;
        duty        = {13'd0, 13'd15, 13'd0, 13'd2};
        center_mode = 1'b1;
        load        = 1'b1;
        step();
        load = 1'b0;
        wait_ack("ctr_ack", 40);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("ctr_count_%0d", i), count, exp_cnt[i]);
            check($sformatf("ctr_pwm_%0d", i), pwm_out[0], exp_pwm[i]);
            if (i < 8) step();
        end
        check("ctr_cs8", cycle_start, 1);
        step();
        clear_acc();
        repeat (8) cyc();
        check("ctr_hi0", hi[0], 3);
        check("ctr_cs", n_cs, 1);

        // Prescale 4, edge P=3, ch0=2.
        prescale    = 5'd4;
        period      = 13'd3;
        duty        = {13'd0, 13'd15, 13'd0, 13'd2};
        center_mode = 1'b0;
        load        = 1'b1;
        step();
        load = 1'b0;
        wait_ack("pre_ack", 40);
        wait_cs("pre_cs_wait", 40);
        clear_acc();
        repeat (20) cyc();
        check("pre_ticks", n_tick, 4);
        check("pre_cs", n_cs, 1);
        check("pre_hi0", hi[0], 10);
        check("pre_period", cycle_start, 1);

        repeat (7) step();
        check("frz_count_pre", count, 1);
        check("frz_pwm_pre", pwm_out[0], 1);
        en        = 1'b0;
        clear_acc();
        n_bad_cnt = 0;
        n_bad_pwm = 0;
        for (int i = 0; i < 7; i++) begin
            if (count !== 13'd1) n_bad_cnt++;
            if (pwm_out[0] !== 1'b1) n_bad_pwm++;
            cyc();
        end
        check("frz_count_held", n_bad_cnt, 0);
        check("frz_pwm_held", n_bad_pwm, 0);
        check("frz_ticks", n_tick, 0);
        check("frz_cs", n_cs, 0);
        en = 1'b1;
        check("res_count", count, 1);
        step();
        step();
        check("res_tick", tick, 1);
        check("res_count_before", count, 1);
        step();
        check("res_count_after", count, 2);
        step();
        check("res_pwm_low", pwm_out[0], 0);

        // Reset while a load is pending.
        prescale = '0;
        period   = 13'd9;
        duty     = {13'd0, 13'd0, 13'd0, 13'd5};
        load     = 1'b1;
        step();
        load = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_zero("mrst");
        clear_acc();
        repeat (30) cyc();
        check("mrst_no_ack", n_ack, 0);
        check("mrst_cs", n_cs, 28);
        check("mrst_hi0", hi[0], 0);
        load = 1'b1;
        step();
        load = 1'b0;
        wait_ack("mrst_new_ack", 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
